// File: rtl/regfile_pkg.sv
// Shared definitions for the MIPS register file: default widths, the
// hardwired zero register index and the clear-engine state type.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_init_fsm.sv
// Post-reset clear engine: walks r1..r(NUM_REGS-1) one index per cycle and
// raises Ready once the last entry has been zeroed.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RF_CLEAR | zeroing mem[clr_cnt] each edge; array not yet usable
//   RF_RUN   | clear done, Ready held high until the next reset
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    rf_state_t         state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              ready_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RF_CLEAR;
            clr_cnt <= FIRST_IDX;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            ready   <= ready_nxt;
        end
    end

    // clr_we is gated by reset so the reset edge itself never touches the array.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready_nxt   = ready;
        clr_we      = 1'b0;
        clr_addr    = clr_cnt;
        case (state)
            RF_CLEAR: begin
                clr_we      = ~reset;
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                if (clr_cnt == LAST_IDX) begin
                    state_nxt = RF_RUN;
                    ready_nxt = 1'b1;
                end
            end
            RF_RUN: begin
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt   = RF_CLEAR;
                clr_cnt_nxt = FIRST_IDX;
                ready_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// MIPS GPR file: 2 combinational read ports, 1 synchronous write port, r0 = 0,
// sequential post-reset clear. Optional write-through: REGFILE_BYPASS_EN.
module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Ready,
    output logic              WrDropped
);

    localparam int                NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem [NUM_REGS];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;

    regfile_init_fsm #(.ADDR_W(ADDR_W)) u_init (
        .clk      (clk),
        .reset    (reset),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (Ready)
    );

    // Clear and user writes are mutually exclusive: user writes need Ready=1.
    assign user_we  = Ready & RegWrite & (WriteReg != ZERO_IDX) & ~reset;
    assign arr_we   = clr_we | user_we;
    assign arr_addr = clr_we ? clr_addr : WriteReg;
    assign arr_data = clr_we ? '0 : WriteData;

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            WrDropped <= 1'b0;
        end else begin
            WrDropped <= RegWrite & ~Ready;
        end
    end

    logic [DATA_W-1:0] raw1, raw2;

    assign raw1 = (ReadReg1 == ZERO_IDX || !Ready) ? '0 : mem[ReadReg1];
    assign raw2 = (ReadReg2 == ZERO_IDX || !Ready) ? '0 : mem[ReadReg2];

`ifdef REGFILE_BYPASS_EN
    logic byp_live;

    assign byp_live  = Ready & RegWrite & (WriteReg != ZERO_IDX);
    assign ReadData1 = (byp_live && WriteReg == ReadReg1) ? WriteData : raw1;
    assign ReadData2 = (byp_live && WriteReg == ReadReg2) ? WriteData : raw2;
`else
    assign ReadData1 = raw1;
    assign ReadData2 = raw2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed checks of reg_file against a behavioural register
// model; build with +define+REGFILE_BYPASS_EN to check the write-through variant.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        Ready;
    logic        WrDropped;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model
    logic [31:0] m_mem [32];
    bit          m_ready;
    bit          m_drop;
    int          m_clear_pos;

    always #5 clk = ~clk;

    reg_file dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .Ready     (Ready),
        .WrDropped (WrDropped)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 0 || !m_ready) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wr != 0 && wr == idx) return wd;
`endif
        return m_mem[idx];
    endfunction

    // Drive one cycle, check the combinational/registered outputs, take the edge,
    // then advance the model by the rules of the register file.
    task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
        reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
        ReadReg1 = a; ReadReg2 = b;
        #1;
        check("rd1", ReadData1, exp_read(a, we, wr, wd));
        check("rd2", ReadData2, exp_read(b, we, wr, wd));
        check("ready", {31'b0, Ready}, {31'b0, m_ready});
        check("wrdrop", {31'b0, WrDropped}, {31'b0, m_drop});
        @(posedge clk);
        if (rst) begin
            m_ready = 0; m_drop = 0; m_clear_pos = 1;
        end else begin
            m_drop = we && !m_ready;
            if (m_ready) begin
                if (we && wr != 0) m_mem[wr] = wd;
            end else begin
                m_mem[m_clear_pos] = 32'h0;
                if (m_clear_pos == 31) m_ready = 1;
                m_clear_pos++;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'($urandom_range(31)), 5'($urandom_range(31)));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        ReadReg1 = '0; ReadReg2 = '0;
        @(posedge clk); #1;
        m_ready = 0; m_drop = 0; m_clear_pos = 1;

        // 1: single reset cycle, then Ready after exactly 31 idle edges
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        for (int i = 1; i <= 31; i++) begin
            idle();
            if (i < 31) check("ready_early", {31'b0, Ready}, 32'h0);
            else        check("ready_edge31", {31'b0, Ready}, 32'h1);
        end
        for (int r = 1; r < 32; r++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(r), 5'(32 - r));
            check("cleared", ReadData1, 32'h0);
        end

        // 2: write then read same register on both ports
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        reset = 0; RegWrite = 0; ReadReg1 = 5'd5; ReadReg2 = 5'd5; #1;
        check("r5_p1", ReadData1, 32'hDEADBEEF);
        check("r5_p2", ReadData2, 32'hDEADBEEF);
        idle();

        // 3: r0 write ignored, no drop pulse
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        reset = 0; RegWrite = 0; ReadReg1 = 5'd0; #1;
        check("r0_zero", ReadData1, 32'h0);
        check("r0_nodrop", {31'b0, WrDropped}, 32'h0);
        idle();

        // 5: same-cycle write/read of r9
        step(1'b0, 1'b1, 5'd9, 32'h11, 5'd0, 5'd0);
        reset = 0; RegWrite = 1; WriteReg = 5'd9; WriteData = 32'hA5A5A5A5;
        ReadReg1 = 5'd1; ReadReg2 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle", ReadData2, 32'hA5A5A5A5);
`else
        check("same_cycle", ReadData2, 32'h00000011);
`endif
        step(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd1, 5'd9);
        reset = 0; RegWrite = 0; ReadReg2 = 5'd9; #1;
        check("after_edge", ReadData2, 32'hA5A5A5A5);

        // random traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(99) == 0), ($urandom_range(1) == 1),
                 5'($urandom_range(31)), $urandom(),
                 5'($urandom_range(31)), 5'($urandom_range(31)));
        end
        while (!m_ready) idle();

        // 6: fill all, reset in RUN, clear with a dropped write at clear edge 10 (test 4)
        for (int r = 1; r < 32; r++) step(1'b0, 1'b1, 5'(r), 32'h1000 + r, 5'(r), 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        check("rst_ready_drop", {31'b0, Ready}, 32'h0);
        check("rst_read0", ReadData1, 32'h0);
        for (int i = 1; i <= 31; i++) begin
            if (i == 10) begin
                step(1'b0, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd7);
                check("wrdrop_pulse", {31'b0, WrDropped}, 32'h1);
            end else begin
                idle();
                if (i == 11) check("wrdrop_once", {31'b0, WrDropped}, 32'h0);
            end
        end
        check("ready_again", {31'b0, Ready}, 32'h1);
        for (int r = 1; r < 32; r++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(r), 5'd7);
            check("post_clear", ReadData1, 32'h0);
        end
        check("r7_zero", ReadData2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
